// File: rtl/is_pkg.sv
// Shared constants and helpers for the systolic-array sum collector.
package is_pkg;

    localparam int DEF_D_W        = 8;
    localparam int DEF_COLS       = 4;
    localparam int DEF_FIFO_DEPTH = 4;

    // A partial sum carries the full product width of two operands.
    function automatic int sum_width(input int d_w);
        return 2 * d_w;
    endfunction

    // Lane c of a packed row starts at bit c*s_w.
    function automatic int lane_lsb(input int lane, input int s_w);
        return lane * s_w;
    endfunction

endpackage

// File: rtl/is_sum_fifo.sv
// Show-ahead FIFO for aligned rows; head is visible on rdata whenever empty is low.
module is_sum_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    // The extra pointer bit distinguishes full from empty when the indices match.
    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg[AW-1:0]] <= wdata;
        end
    end

    assign rdata = mem[rd_ptr_reg[AW-1:0]];

endmodule

// File: rtl/is_sum_collector.sv
// Deskews the bottom-row partial sums of a systolic array and queues whole rows.
// Define IS_COLLECT_RELU_EN to clamp negative lanes to zero as rows enter the FIFO.
module is_sum_collector
    import is_pkg::*;
#(
    parameter int D_W        = DEF_D_W,
    parameter int COLS       = DEF_COLS,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    input  logic [COLS*sum_width(D_W)-1:0]    in_sum,
    input  logic                              clr_ovf,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [COLS*sum_width(D_W)-1:0]    out_data,
    output logic                              ovf,
    output logic [7:0]                        row_cnt
);

    localparam int S_W   = sum_width(D_W);
    localparam int ROW_W = COLS * S_W;

    logic [COLS-2:0]  valid_pipe_reg;
    logic             aligned_valid;
    logic [ROW_W-1:0] aligned_row;
    logic [ROW_W-1:0] push_row;

    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_pop;
    logic             push_accept;
    logic             push_drop;
    logic [ROW_W-1:0] fifo_rdata;

    logic             ovf_reg;
    logic             ovf_next;
    logic [7:0]       row_cnt_reg;
    logic [7:0]       row_cnt_next;

    // Lane c arrives c cycles after lane 0, so it waits COLS-1-c cycles to line up.
    for (genvar gi = 0; gi < COLS; gi++) begin : g_lane
        localparam int STAGES = COLS - 1 - gi;
        localparam int LSB    = lane_lsb(gi, S_W);

        if (STAGES == 0) begin : g_direct
            assign aligned_row[LSB +: S_W] = in_sum[LSB +: S_W];
        end else begin : g_delay
            logic [S_W-1:0] dly_reg [STAGES];

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    for (int i = 0; i < STAGES; i++) begin
                        dly_reg[i] <= '0;
                    end
                end else begin
                    dly_reg[0] <= in_sum[LSB +: S_W];
                    for (int i = 1; i < STAGES; i++) begin
                        dly_reg[i] <= dly_reg[i-1];
                    end
                end
            end

            assign aligned_row[LSB +: S_W] = dly_reg[STAGES-1];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_pipe_reg <= '0;
        end else begin
            valid_pipe_reg[0] <= in_valid;
            for (int i = 1; i < COLS - 1; i++) begin
                valid_pipe_reg[i] <= valid_pipe_reg[i-1];
            end
        end
    end

    assign aligned_valid = valid_pipe_reg[COLS-2];

    for (genvar gi = 0; gi < COLS; gi++) begin : g_relu
        localparam int LSB = lane_lsb(gi, S_W);
`ifdef IS_COLLECT_RELU_EN
        assign push_row[LSB +: S_W] = aligned_row[LSB + S_W - 1] ? '0 : aligned_row[LSB +: S_W];
`else
        assign push_row[LSB +: S_W] = aligned_row[LSB +: S_W];
`endif
    end

    // A pop in the same cycle frees the slot, so a full FIFO only drops without one.
    assign fifo_pop    = out_ready && !fifo_empty;
    assign push_accept = aligned_valid && (!fifo_full || fifo_pop);
    assign push_drop   = aligned_valid && fifo_full && !fifo_pop;

    is_sum_fifo #(
        .WIDTH (ROW_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_accept),
        .pop   (fifo_pop),
        .wdata (push_row),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        ovf_next     = ovf_reg;
        row_cnt_next = row_cnt_reg;
        if (push_drop) begin
            ovf_next = 1'b1;
        end else if (clr_ovf) begin
            ovf_next = 1'b0;
        end
        if (push_accept) begin
            row_cnt_next = row_cnt_reg + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_reg     <= 1'b0;
            row_cnt_reg <= '0;
        end else begin
            ovf_reg     <= ovf_next;
            row_cnt_reg <= row_cnt_next;
        end
    end

    // Unwritten FIFO slots are masked so the output is clean whenever nothing is queued.
    assign out_valid = !fifo_empty;
    assign out_data  = fifo_empty ? '0 : fifo_rdata;
    assign ovf       = ovf_reg;
    assign row_cnt   = row_cnt_reg;

endmodule

// File: tb/tb_is_sum_collector.sv
// Scoreboard bench for is_sum_collector: skewed row driver, queue of expected rows, popping monitor.
`timescale 1ns/1ps
module tb_is_sum_collector;

    localparam int D_W        = 8;
    localparam int COLS       = 4;
    localparam int FIFO_DEPTH = 4;
    localparam int S_W        = 2 * D_W;
    localparam int ROW_W      = COLS * S_W;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             in_valid = 1'b0;
    logic [ROW_W-1:0] in_sum = '0;
    logic             clr_ovf = 1'b0;
    logic             out_ready = 1'b0;
    logic             out_valid;
    logic [ROW_W-1:0] out_data;
    logic             ovf;
    logic [7:0]       row_cnt;

    int tests = 0;
    int fails = 0;

    logic [ROW_W-1:0] exp_q [$];
    logic             hist_v [COLS];
    logic [ROW_W-1:0] hist_r [COLS];

    always #5 clk = ~clk;

    is_sum_collector #(
        .D_W        (D_W),
        .COLS       (COLS),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_sum    (in_sum),
        .clr_ovf   (clr_ovf),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .ovf       (ovf),
        .row_cnt   (row_cnt)
    );

    function automatic logic [ROW_W-1:0] mk_row(input int k);
        logic [ROW_W-1:0] r;
        for (int c = 0; c < COLS; c++) begin
            r[c*S_W +: S_W] = 16'(16'h0100 * k + 16'h0011 * (c + 1));
        end
        return r;
    endfunction

    task automatic check_row(input string name, input logic [ROW_W-1:0] act, input logic [ROW_W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("[TB] ok %s = %h", name, act);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end else begin
            $display("[TB] ok %s = %0d", name, act);
        end
    endtask

    // Monitor: every accepted output row is compared against the head of the queue.
    always @(negedge clk) begin
        if (rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_row: got %h expected none", out_data);
            end else begin
                check_row("pop_row", out_data, exp_q.pop_front());
            end
        end
    end

    // One cycle: lane c carries the row issued c cycles earlier.
    task automatic step(input logic v, input logic [ROW_W-1:0] row, input logic rdy, input logic clr);
        for (int i = COLS - 1; i > 0; i--) begin
            hist_v[i] = hist_v[i-1];
            hist_r[i] = hist_r[i-1];
        end
        hist_v[0] = v;
        hist_r[0] = row;
        in_valid  = v;
        for (int c = 0; c < COLS; c++) begin
            in_sum[c*S_W +: S_W] = hist_v[c] ? hist_r[c][c*S_W +: S_W] : '0;
        end
        out_ready = rdy;
        clr_ovf   = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input logic rdy);
        repeat (n) step(1'b0, '0, rdy, 1'b0);
    endtask

    task automatic issue(input logic [ROW_W-1:0] row, input logic rdy, input logic expect_kept);
        if (expect_kept) exp_q.push_back(row);
        step(1'b1, row, rdy, 1'b0);
    endtask

    task automatic clear_stim();
        in_valid  = 1'b0;
        in_sum    = '0;
        out_ready = 1'b0;
        clr_ovf   = 1'b0;
        for (int i = 0; i < COLS; i++) begin
            hist_v[i] = 1'b0;
            hist_r[i] = '0;
        end
        exp_q.delete();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        clear_stim();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            step(1'b0, '0, 1'b1, 1'b0);
            n++;
        end
        check_int("drain_rows_left", exp_q.size(), 0);
    endtask

    initial begin
        logic [ROW_W-1:0] relu_in;
        logic [ROW_W-1:0] relu_exp;

        clear_stim();
        #2;
        check_int("rst_out_valid", int'(out_valid), 0);
        check_int("rst_ovf", int'(ovf), 0);
        check_int("rst_row_cnt", int'(row_cnt), 0);
        check_row("rst_out_data", out_data, '0);

        // Single row: exact COLS-cycle latency with lanes 0011..0044.
        do_reset();
        issue(mk_row(0), 1'b1, 1'b1);
        for (int k = 1; k < COLS; k++) begin
            check_int($sformatf("lat_cycle%0d_out_valid", k), int'(out_valid), 0);
            idle(1, 1'b1);
        end
        check_int("lat_cycle4_out_valid", int'(out_valid), 1);
        check_row("lat_cycle4_out_data", out_data, 64'h0044_0033_0022_0011);
        check_int("lat_row_cnt", int'(row_cnt), 1);
        idle(1, 1'b1);
        check_int("lat_cycle5_out_valid", int'(out_valid), 0);

        // Back-to-back rows with a ready consumer.
        do_reset();
        for (int k = 1; k <= 8; k++) issue(mk_row(k), 1'b1, 1'b1);
        wait_drain(COLS + 2);
        check_int("b2b_ovf", int'(ovf), 0);
        check_int("b2b_row_cnt", int'(row_cnt), 8);

        // Overflow: five rows into a stalled four-entry FIFO.
        do_reset();
        for (int k = 1; k <= 5; k++) issue(mk_row(10 + k), 1'b0, (k <= 4));
        idle(COLS, 1'b0);
        check_int("ovf_set", int'(ovf), 1);
        check_int("ovf_row_cnt", int'(row_cnt), 4);
        check_int("ovf_out_valid", int'(out_valid), 1);
        check_row("ovf_head", out_data, mk_row(11));
        idle(1, 1'b0);
        check_row("ovf_head_stable", out_data, mk_row(11));
        wait_drain(FIFO_DEPTH + 2);
        check_int("ovf_row_cnt_after_drain", int'(row_cnt), 4);
        check_int("ovf_out_valid_after_drain", int'(out_valid), 0);

        // Full FIFO: push and pop together, then drop while clearing.
        do_reset();
        for (int k = 1; k <= 5; k++) issue(mk_row(20 + k), 1'b0, 1'b1);
        idle(2, 1'b0);
        idle(1, 1'b1);
        check_int("fullpp_ovf", int'(ovf), 0);
        check_int("fullpp_row_cnt", int'(row_cnt), 5);
        check_row("fullpp_head", out_data, mk_row(22));
        issue(mk_row(26), 1'b0, 1'b0);
        idle(3, 1'b0);
        check_int("drop_ovf", int'(ovf), 1);
        check_int("drop_row_cnt", int'(row_cnt), 5);
        issue(mk_row(27), 1'b0, 1'b0);
        idle(2, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1);
        check_int("drop_and_clr_ovf", int'(ovf), 1);
        step(1'b0, '0, 1'b0, 1'b1);
        check_int("clr_only_ovf", int'(ovf), 0);
        wait_drain(FIFO_DEPTH + 2);
        check_int("fullpp_final_row_cnt", int'(row_cnt), 5);

        // Reset with two rows buffered and one in flight.
        do_reset();
        issue(mk_row(31), 1'b0, 1'b1);
        issue(mk_row(32), 1'b0, 1'b1);
        idle(2, 1'b0);
        issue(mk_row(33), 1'b0, 1'b1);
        idle(1, 1'b0);
        check_int("pre_rst_row_cnt", int'(row_cnt), 2);
        #2;
        rst = 1'b0;
        #1;
        check_int("mid_rst_out_valid", int'(out_valid), 0);
        check_int("mid_rst_row_cnt", int'(row_cnt), 0);
        check_row("mid_rst_out_data", out_data, '0);
        clear_stim();
        @(posedge clk);
        #1;
        rst = 1'b1;
        idle(COLS + 2, 1'b1);
        check_int("post_rst_out_valid", int'(out_valid), 0);
        check_int("post_rst_row_cnt", int'(row_cnt), 0);
        issue(mk_row(34), 1'b1, 1'b1);
        idle(COLS - 1, 1'b1);
        check_int("post_rst_lat_out_valid", int'(out_valid), 1);
        wait_drain(2);

        // Negative lanes: clamped only when the ReLU build is selected.
        do_reset();
        relu_in = {16'h7FFF, 16'h8000, 16'h0010, 16'hFFF0};
`ifdef IS_COLLECT_RELU_EN
        relu_exp = {16'h7FFF, 16'h0000, 16'h0010, 16'h0000};
`else
        relu_exp = {16'h7FFF, 16'h8000, 16'h0010, 16'hFFF0};
`endif
        issue(relu_in, 1'b0, 1'b0);
        exp_q.push_back(relu_exp);
        idle(COLS - 1, 1'b0);
        check_row("relu_head", out_data, relu_exp);
        wait_drain(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
